// File: rtl/ysyx_22040127_ifu.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight and
// hands fetched instructions to decode. Redirects from ID and WB cancel in-flight work.
module ysyx_22040127_ifu #(
  parameter logic [31:0] RESET_PC = 32'h80000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_allowin,
  input  logic        id_branch_taken,
  input  logic [31:0] id_branch_result,
  input  logic        wb_mret,
  input  logic [31:0] wb_mepc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [63:0] imem_resp_data,
  output logic        if_to_id_valid,
  output logic [63:0] if_to_id_bus,
  output logic [31:0] if_pc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] inst_reg, inst_next;
  logic        drop_reg, drop_next;

  logic        redir;
  logic [31:0] redir_target;
  logic        kill_inst;

  // WB is older than ID, so its redirect takes priority.
  assign redir        = wb_mret | id_branch_taken;
  assign redir_target = wb_mret ? wb_mepc : id_branch_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      inst_reg  <= 32'h0;
      drop_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      inst_reg  <= inst_next;
      drop_reg  <= drop_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    inst_next  = inst_reg;
    drop_next  = drop_reg;
    if (redir) begin
      pc_next = redir_target;
    end
    case (state_reg)
      IDLE: state_next = REQ;
      REQ: begin
        // A redirect without acceptance simply retargets the pending request.
        if (imem_req_ready) begin
          state_next = WAIT;
          drop_next  = redir;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          drop_next = 1'b0;
          if (drop_reg || redir) begin
            state_next = REQ;
          end else begin
            inst_next  = pc_reg[2] ? imem_resp_data[63:32] : imem_resp_data[31:0];
            state_next = HOLD;
          end
        end else if (redir) begin
          drop_next = 1'b1;
        end
      end
      HOLD: begin
        if (redir) begin
          inst_next  = 32'h0;
          state_next = REQ;
        end else if (id_allowin) begin
          pc_next    = pc_reg + 32'd4;
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Instruction being redirected away is turned into a bubble the same cycle.
  assign kill_inst = (state_reg == HOLD) && redir;

  assign imem_req_valid = ~rst && (state_reg == REQ);
  assign imem_req_addr  = {pc_reg[31:3], 3'b000};
  assign if_to_id_valid = ~rst && (state_reg == HOLD);
  assign if_to_id_bus   = rst ? 64'h0 : {(kill_inst ? 32'h0 : inst_reg), pc_reg};
  assign if_pc          = pc_reg;

endmodule

// File: tb/tb_ysyx_22040127_ifu.sv
// Bench for the fetch stage: directed scenarios plus a randomized run checked
// against a PC-stream model and an address-hashed instruction memory.
module tb_ysyx_22040127_ifu;

  localparam logic [31:0] RESET_PC = 32'h80000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_allowin = 1'b0;
  logic        id_branch_taken = 1'b0;
  logic [31:0] id_branch_result = 32'h0;
  logic        wb_mret = 1'b0;
  logic [31:0] wb_mepc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [63:0] imem_resp_data = 64'h0;
  logic        if_to_id_valid;
  logic [63:0] if_to_id_bus;
  logic [31:0] if_pc;

  always #5 clk = ~clk;

  ysyx_22040127_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_allowin       (id_allowin),
    .id_branch_taken  (id_branch_taken),
    .id_branch_result (id_branch_result),
    .wb_mret          (wb_mret),
    .wb_mepc          (wb_mepc),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_resp_valid  (imem_resp_valid),
    .imem_resp_data   (imem_resp_data),
    .if_to_id_valid   (if_to_id_valid),
    .if_to_id_bus     (if_to_id_bus),
    .if_pc            (if_pc)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model and reference state
  bit          fixed_data = 1'b1;
  int          dmin = 1, dmax = 1;
  bit          inject_en = 1'b0;
  bit          force_resp = 1'b0;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] exp_pc = RESET_PC;
  int          cyc = 0;
  logic [63:0] log_bus[$];
  int          log_cyc[$];

  logic        s_req_valid, s_valid;
  logic [31:0] s_addr, s_pc;
  logic [63:0] s_bus;

  function automatic logic [31:0] inst_hash(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] p);
    if (fixed_data) return p[2] ? 32'h00000013 : 32'h00100093;
    return inst_hash({p[31:2], 2'b00});
  endfunction

  function automatic logic [63:0] mem_data(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:3], 3'b000};
    if (fixed_data) return {32'h00000013, 32'h00100093};
    return {inst_hash(b | 32'd4), inst_hash(b)};
  endfunction

  task automatic sample_outputs();
    s_req_valid = imem_req_valid;
    s_addr      = imem_req_addr;
    s_valid     = if_to_id_valid;
    s_bus       = if_to_id_bus;
    s_pc        = if_pc;
  endtask

  task automatic reset_step();
    @(negedge clk);
    rst             = 1'b1;
    imem_req_ready  = 1'b0;
    id_allowin      = 1'b0;
    id_branch_taken = 1'b0;
    wb_mret         = 1'b0;
    imem_resp_valid = 1'b0;
    #1;
    sample_outputs();
    check_val("rst_req_valid", s_req_valid, 0);
    check_val("rst_id_valid", s_valid, 0);
    check_val("rst_bus", s_bus, 64'h0);
    pend   = 1'b0;
    exp_pc = RESET_PC;
    cyc++;
  endtask

  task automatic step(input bit ready, input bit allowin, input bit br, input logic [31:0] bt,
                      input bit mr, input logic [31:0] mt);
    bit          fired;
    bit          redir;
    logic [31:0] tgt;
    @(negedge clk);
    rst              = 1'b0;
    imem_req_ready   = ready;
    id_allowin       = allowin;
    id_branch_taken  = br;
    id_branch_result = bt;
    wb_mret          = mr;
    wb_mepc          = mt;
    fired = 1'b0;
    if (pend && cnt == 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_data(pend_addr);
      fired = 1'b1;
    end else if (force_resp || (inject_en && !pend && $urandom_range(0, 9) == 0)) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = {$urandom, $urandom};
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = {$urandom, $urandom};
    end
    force_resp = 1'b0;
    #1;
    sample_outputs();
    redir = br | mr;
    tgt   = mr ? mt : bt;

    check_val("if_pc", s_pc, exp_pc);
    if (s_req_valid) begin
      check_val("req_addr", s_addr, {exp_pc[31:3], 3'b000});
      check_val("one_outstanding", pend, 0);
      check_val("req_vs_valid", s_valid, 0);
    end
    if (s_valid) begin
      if (redir) check_val("bus_killed", s_bus, {32'h0, exp_pc});
      else       check_val("bus", s_bus, {exp_inst(exp_pc), exp_pc});
    end

    if (fired) pend = 1'b0;
    if (s_req_valid && ready) begin
      pend      = 1'b1;
      pend_addr = s_addr;
      cnt       = int'($urandom_range(dmin, dmax)) - 1;
    end else if (pend) begin
      cnt--;
    end

    if (s_valid && allowin && !redir) begin
      log_bus.push_back(s_bus);
      log_cyc.push_back(cyc);
    end
    if (redir)                   exp_pc = tgt;
    else if (s_valid && allowin) exp_pc = exp_pc + 32'd4;
    cyc++;
  endtask

  initial begin
    bit          got;
    logic [63:0] held_bus;
    logic [31:0] held_pc;
    logic [31:0] bt, mt;
    int          r;

    // Basic streaming with fixed data
    fixed_data = 1'b1; dmin = 1; dmax = 1; inject_en = 1'b0;
    reset_step();
    reset_step();
    step(1, 1, 0, 0, 0, 0);
    check_val("idle_no_req", s_req_valid, 0);
    log_bus.delete(); log_cyc.delete();
    for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 0, 0);
    check_val("t1_count", log_bus.size() >= 2, 1);
    if (log_bus.size() >= 2) begin
      check_val("t1_bus0", log_bus[0], 64'h00100093_80000000);
      check_val("t1_bus1", log_bus[1], 64'h00000013_80000004);
      check_val("t1_period", log_cyc[1] - log_cyc[0], 3);
    end

    // Decode stalls while an instruction is held
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 0, 0);
      if (s_valid) begin got = 1'b1; break; end
    end
    check_val("t2_reach_hold", got, 1);
    held_bus = s_bus;
    held_pc  = s_pc;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 0, 0);
      check_val("t2_valid_held", s_valid, 1);
      check_val("t2_bus_held", s_bus, held_bus);
      check_val("t2_no_req", s_req_valid, 0);
      check_val("t2_pc_held", s_pc, held_pc);
    end
    step(1, 1, 0, 0, 0, 0);

    // Memory back-pressure on the first request
    fixed_data = 1'b0; dmin = 2; dmax = 2;
    reset_step();
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0);
      check_val("t3_req_held", s_req_valid, 1);
      check_val("t3_addr_stable", s_addr, RESET_PC);
    end
    step(1, 0, 0, 0, 0, 0);
    check_val("t3_accepted", s_req_valid, 1);

    // Branch redirect while waiting for the response
    step(1, 0, 1, 32'h80000100, 0, 0);
    got = 1'b0;
    log_bus.delete(); log_cyc.delete();
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 0, 0, 0);
      if (s_req_valid) begin
        check_val("t4_req_addr", s_addr, 32'h80000100);
        got = 1'b1;
        break;
      end
    end
    check_val("t4_req_seen", got, 1);
    for (int i = 0; i < 10 && log_bus.size() == 0; i++) step(1, 1, 0, 0, 0, 0);
    check_val("t4_delivered", log_bus.size(), 1);
    if (log_bus.size() > 0) check_val("t4_first_pc", log_bus[0][31:0], 32'h80000100);

    // Simultaneous mret and branch while holding: WB wins, inst killed
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 0, 0);
      if (s_valid) begin got = 1'b1; break; end
    end
    check_val("t5_reach_hold", got, 1);
    step(1, 1, 1, 32'h80000100, 1, 32'h80000200);
    check_val("t5_valid", s_valid, 1);
    check_val("t5_inst_killed", s_bus[63:32], 32'h0);
    got = 1'b0;
    log_bus.delete(); log_cyc.delete();
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 0, 0, 0);
      if (s_req_valid) begin
        check_val("t5_req_addr", s_addr, 32'h80000200);
        got = 1'b1;
        break;
      end
    end
    check_val("t5_req_seen", got, 1);
    for (int i = 0; i < 10 && log_bus.size() == 0; i++) step(1, 1, 0, 0, 0, 0);
    check_val("t5_delivered", log_bus.size(), 1);
    if (log_bus.size() > 0) check_val("t5_first_pc", log_bus[0][31:0], 32'h80000200);

    // Reset while waiting, stray response right after reset
    dmin = 3; dmax = 3;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 0, 0, 0);
      if (s_req_valid) begin got = 1'b1; break; end
    end
    check_val("t6_req_before_rst", got, 1);
    step(1, 1, 0, 0, 0, 0);
    reset_step();
    force_resp = 1'b1;
    step(1, 1, 0, 0, 0, 0);
    check_val("t6_idle_valid", s_valid, 0);
    check_val("t6_idle_req", s_req_valid, 0);
    got = 1'b0;
    log_bus.delete(); log_cyc.delete();
    for (int i = 0; i < 12 && log_bus.size() == 0; i++) begin
      step(1, 1, 0, 0, 0, 0);
      if (s_req_valid && !got) begin
        check_val("t6_first_addr", s_addr, RESET_PC);
        got = 1'b1;
      end
    end
    check_val("t6_req_seen", got, 1);
    check_val("t6_delivered", log_bus.size(), 1);
    if (log_bus.size() > 0) check_val("t6_first_bus", log_bus[0], {inst_hash(RESET_PC), RESET_PC});

    // Randomized traffic, including redirects near the top of the address space
    dmin = 1; dmax = 3; inject_en = 1'b1;
    log_bus.delete(); log_cyc.delete();
    for (int i = 0; i < 1500; i++) begin
      r  = int'($urandom_range(0, 99));
      bt = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | ($urandom_range(0, 3) << 2))
                                       : (32'h80000000 | ($urandom_range(0, 255) << 2));
      mt = 32'h80001000 | ($urandom_range(0, 255) << 2);
      step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60, r < 6, bt, r >= 94, mt);
    end
    check_val("rand_progress", log_bus.size() >= 50, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
